// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, sync/bright decode,
// frame tick/count and optional game clock (enable with VGA_GAME_CLK_EN).
// Ports: clk, rst_n in; hCount, vCount, hSync, vSync, bright, pix_en,
// frame_tick, frame_cnt, game_clk out.
module vga_sync_gen #(
  parameter int PIX_DIV    = 4,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int H_SYNC     = 96,
  parameter int V_SYNC     = 2,
  parameter int H_BR_START = 144,
  parameter int H_BR_END   = 783,
  parameter int V_BR_START = 35,
  parameter int V_BR_END   = 514,
  parameter int GAME_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic [15:0] frame_cnt,
  output logic        game_clk
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt;
  logic          h_last;
  logic          v_last;
  logic          wrap;

  assign pix_en = (div_cnt == DIV_MAX);
  assign h_last = (hCount == H_MAX);
  assign v_last = (vCount == V_MAX);
  assign wrap   = pix_en && h_last && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hCount <= '0;
        vCount <= v_last ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  assign hSync  = (hCount >= 10'(H_SYNC));
  assign vSync  = (vCount >= 10'(V_SYNC));
  assign bright = (hCount >= 10'(H_BR_START)) &&
                  (hCount <= 10'(H_BR_END)) &&
                  (vCount >= 10'(V_BR_START)) &&
                  (vCount <= 10'(V_BR_END));

  // frame_cnt advances on the wrap edge so it already reads the new
  // total in the cycle frame_tick is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= wrap;
      if (wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef VGA_GAME_CLK_EN
  localparam int GW = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
  localparam logic [GW-1:0] G_MAX = GW'(GAME_DIV - 1);

  logic [GW-1:0] fdiv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdiv     <= '0;
      game_clk <= 1'b0;
    end else if (wrap) begin
      if (fdiv == G_MAX) begin
        fdiv     <= '0;
        game_clk <= ~game_clk;
      end else begin
        fdiv <= fdiv + 1'b1;
      end
    end
  end
`else
  assign game_clk = 1'b0;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameter H_TOTAL, default 800: pixel clocks per line.
REQ-003 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-004 SHALL have parameter H_SYNC, default 96: hSync low width, in pixels.
REQ-005 SHALL have parameter V_SYNC, default 2: vSync low width, in lines.
REQ-006 SHALL have parameters H_BR_START=144, H_BR_END=783, V_BR_START=35, V_BR_END=514: inclusive visible window.
REQ-007 SHALL have parameter GAME_DIV, default 2: frames per game_clk half-period.
REQ-008 clk  input  1: system clock, 100 MHz; all flops on its rising edge.
REQ-009 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-010 hCount  output  10: horizontal pixel position, 0..H_TOTAL-1.
REQ-011 vCount  output  10: vertical line position, 0..V_TOTAL-1.
REQ-012 hSync  output  1: horizontal sync, active-low.
REQ-013 vSync  output  1: vertical sync, active-low.
REQ-014 bright  output  1: high inside the visible window.
REQ-015 pix_en  output  1: one-clk pixel strobe.
REQ-016 frame_tick  output  1: one-clk pulse at each frame start.
REQ-017 frame_cnt  output  16: count of completed frames.
REQ-018 game_clk  output  1: slow movement clock for the position/colour controller.

Function
REQ-019 div_cnt SHALL count 0..PIX_DIV-1 and wrap to 0; pix_en SHALL be high exactly in clk cycles where div_cnt==PIX_DIV-1.
REQ-020 On each clk edge with pix_en high, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL increment in the same edge.
REQ-021 vCount SHALL wrap from V_TOTAL-1 to 0 only on the edge that wraps hCount from H_TOTAL-1.
REQ-022 hCount and vCount SHALL hold their values on edges where pix_en is low.
REQ-023 hSync SHALL be low iff hCount<H_SYNC; vSync SHALL be low iff vCount<V_SYNC; decode is combinational from the counter registers, with zero latency.
REQ-024 bright SHALL be high iff H_BR_START<=hCount<=H_BR_END and V_BR_START<=vCount<=V_BR_END; this gives 640x480 visible pixels.
REQ-025 frame_tick SHALL be registered and high for exactly one clk cycle: the cycle after the edge on which (hCount,vCount) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-026 frame_tick SHALL NOT assert on reset release.
REQ-027 frame_cnt SHALL increment by 1 on each frame_tick and wrap from 16'hFFFF to 0.
REQ-028 Counter widths SHALL be 10 bits; the H_TOTAL and V_TOTAL parameters SHALL be <=1024.

Reset
REQ-029 While rst_n is low: div_cnt, hCount, vCount and frame_cnt SHALL be 0, and frame_tick, game_clk and pix_en SHALL be 0; hSync and vSync SHALL be 0 by decode.
REQ-030 Reset asserted mid-line or mid-frame SHALL clear all state immediately, without waiting for a clk edge.
REQ-031 After rst_n rises, the first pix_en SHALL occur PIX_DIV clk edges later.

Configuration
REQ-032 With macro VGA_GAME_CLK_EN defined, game_clk SHALL toggle on every GAME_DIV-th frame_tick, using an internal frame divider reset to 0.
REQ-033 With GAME_DIV=2 this SHALL give a 15 Hz square wave.
REQ-034 Without VGA_GAME_CLK_EN, game_clk SHALL be tied to 0 and the divider logic SHALL be absent.

Verification
REQ-035 Reset and divider: hold rst_n low for 10 clks, then release -> all outputs 0 during reset; pix_en first high on the 4th clk edge, then every 4 clks.
REQ-036 Line wrap: run 3200 clks -> hCount sequence 0..799 then 0, and vCount steps 0->1 on the same edge; hSync low for exactly 384 clks per line.
REQ-037 Frame wrap: run 1,680,000 clks -> exactly one frame_tick; frame_cnt=1; vSync low for exactly 2 lines (6400 clks).
REQ-038 Visible window: count bright-high pix_en strobes over one frame -> 307200, with bright first high at (144,35) and last at (783,514).
REQ-039 Mid-frame reset: pulse rst_n low at hCount=500, vCount=300 -> counters go to 0 asynchronously; no frame_tick on release.
REQ-040 Game clock: with VGA_GAME_CLK_EN defined and 8 frames run -> game_clk toggles after frames 2, 4, 6 and 8; with the macro undefined -> game_clk stays 0.
